alu_cmd_sequencer: RTL and testbench

Command-driven front end that issues work to the 16-bit ALU and returns its results. It accepts opcode/operand commands through a valid/ready port and buffers them in a small FIFO. For each command it drives the ALU's a, b, acc and opcode inputs, captures out/err, and writes the accumulator back. Each completed command produces a response on a valid/ready port.

---
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Queues opcode/operand commands, issues them one at a time to the ALU, returns results.
// Optional ALUSEQ_ERR_HOLD_EN: keep the accumulator unchanged when the ALU flags an error.
module alu_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int ILLEGAL_MIN = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] rsp_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_acc,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_out,
  input  logic        alu_err,
  input  logic        alu_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] NOP = 5'd25;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC,
    RESP
  } state_t;

  state_t state_q, state_d;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_q;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, push, pop;

  logic [15:0] acc_q, acc_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        is_ill, is_clr, is_nop;

  assign full      = cnt == (AW+1)'(DEPTH);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (cnt != '0);

  assign rsp_valid = state_q == RESP;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_acc   = acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cnt != '0) state_d = ISSUE;
      ISSUE: state_d = EXEC;
      EXEC:  state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conditions are made mutually exclusive so the decoder can be unique.
  assign is_ill = cmd_q.op >= 5'(ILLEGAL_MIN);
  assign is_clr = !is_ill && (cmd_q.op == 5'd0 || alu_clr);
  assign is_nop = !is_ill && !is_clr && cmd_q.op == NOP;

  always_comb begin
    data_d = alu_out;
    err_d  = alu_err;
    acc_d  = alu_out[15:0];
    unique case (1'b1)
      is_ill: begin
        data_d = '0;
        err_d  = 1'b1;
        acc_d  = acc_q;
      end
      is_clr: begin
        data_d = '0;
        err_d  = 1'b0;
        acc_d  = '0;
      end
      is_nop: begin
        data_d = {16'b0, acc_q};
        acc_d  = acc_q;
      end
      default: begin
`ifdef ALUSEQ_ERR_HOLD_EN
        if (alu_err) acc_d = acc_q;
`else
        acc_d = alu_out[15:0];
`endif
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_acc    <= '0;
      alu_opcode <= NOP;
      acc_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) cmd_q <= mem[rp];
      if (state_q == ISSUE) begin
        alu_a      <= cmd_q.a;
        alu_b      <= cmd_q.b;
        alu_acc    <= acc_q;
        alu_opcode <= is_ill ? NOP : cmd_q.op;
      end
      if (state_q == EXEC) begin
        data_q <= data_d;
        err_q  <= err_d;
        acc_q  <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a small combinational ALU model.
// Expected accumulator after an ALU error follows ALUSEQ_ERR_HOLD_EN.
module tb_alu_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_opcode;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] rsp_acc;
  logic [15:0] alu_a, alu_b, alu_acc;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_out;
  logic        alu_err;
  logic        alu_clr;

  always #5 clock = ~clock;

  alu_cmd_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_acc(rsp_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc),
    .alu_opcode(alu_opcode), .alu_out(alu_out),
    .alu_err(alu_err), .alu_clr(alu_clr)
  );

  // ALU model: 0 clear, 4 divide, 6 add, 8 multiply, 18 acc+b, 25 no-op
  always_comb begin
    alu_out = 32'd0;
    alu_err = 1'b0;
    alu_clr = alu_opcode == 5'd0;
    case (alu_opcode)
      5'd0:  alu_out = 32'd0;
      5'd4: begin
        if (alu_b == 16'd0) begin
          alu_out = 32'hFFFF_FFFF;
          alu_err = 1'b1;
        end else begin
          alu_out = 32'(alu_a / alu_b);
        end
      end
      5'd6:  alu_out = 32'(alu_a) + 32'(alu_b);
      5'd8:  alu_out = 32'(alu_a) * 32'(alu_b);
      5'd18: alu_out = 32'(alu_acc) + 32'(alu_b);
      5'd25: alu_out = 32'd0;
      default: alu_out = 32'(alu_a ^ alu_b);
    endcase
  end

`ifdef ALUSEQ_ERR_HOLD_EN
  localparam logic [15:0] DIV_ACC = 16'd6;
`else
  localparam logic [15:0] DIV_ACC = 16'hFFFF;
`endif

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [15:0] acc;
    logic [4:0]  op;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%h required=none",
                 rsp_data);
      end else begin
        got = sb.pop_front();
        chk("rsp_data", rsp_data, got.d);
        chk("rsp_err", 32'(rsp_err), 32'(got.e));
        chk("rsp_acc", 32'(rsp_acc), 32'(got.acc));
        chk("alu_opcode", 32'(alu_opcode), 32'(got.op));
      end
    end
  end

  task automatic send(input logic [4:0] op,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [31:0] d,
                      input logic e,
                      input logic [15:0] acc,
                      input bit keep);
    int n = 0;
    exp_t x;
    @(negedge clock);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end else begin
      x.d   = d;
      x.e   = e;
      x.acc = acc;
      x.op  = (op >= 5'd26) ? 5'd25 : op;
      if (keep) sb.push_back(x);
      @(posedge clock);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0",
               sb.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_acc", 32'(rsp_acc), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd25);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    reset = 1'b0;

    send(5'd6, 16'd3, 16'd2, 32'd5, 1'b0, 16'd5, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("lat_n3_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk("lat_n4_valid", 32'(rsp_valid), 32'd1);

    send(5'd0,  16'd0, 16'd0, 32'd0, 1'b0, 16'd0, 1'b1);
    send(5'd25, 16'd3, 16'd2, 32'd0, 1'b0, 16'd0, 1'b1);
    send(5'd18, 16'd0, 16'd2, 32'd2, 1'b0, 16'd2, 1'b1);
    send(5'd18, 16'd0, 16'd2, 32'd4, 1'b0, 16'd4, 1'b1);
    send(5'd18, 16'd0, 16'd2, 32'd6, 1'b0, 16'd6, 1'b1);
    send(5'd8,  16'd3, 16'd2, 32'd6, 1'b0, 16'd6, 1'b1);
    send(5'd4,  16'd13, 16'd0, 32'hFFFF_FFFF, 1'b1,
         DIV_ACC, 1'b1);
    send(5'd0,  16'd0, 16'd0, 32'd0, 1'b0, 16'd0, 1'b1);
    send(5'd6,  16'd3, 16'd2, 32'd5, 1'b0, 16'd5, 1'b1);
    send(5'd27, 16'd1, 16'd1, 32'd0, 1'b1, 16'd5, 1'b1);
    drain();

    @(negedge clock);
    rsp_ready = 1'b0;
    send(5'd18, 16'd0, 16'd1, 32'd6,  1'b0, 16'd6,  1'b1);
    send(5'd18, 16'd0, 16'd2, 32'd8,  1'b0, 16'd8,  1'b1);
    send(5'd18, 16'd0, 16'd3, 32'd11, 1'b0, 16'd11, 1'b1);
    send(5'd18, 16'd0, 16'd4, 32'd15, 1'b0, 16'd15, 1'b1);
    send(5'd18, 16'd0, 16'd5, 32'd20, 1'b0, 16'd20, 1'b1);
    repeat (3) @(negedge clock);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    drain();

    send(5'd6, 16'd1, 16'd1, 32'd0, 1'b0, 16'd0, 1'b0);
    send(5'd6, 16'd2, 16'd2, 32'd0, 1'b0, 16'd0, 1'b0);
    send(5'd6, 16'd3, 16'd3, 32'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_acc", 32'(rsp_acc), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    chk("mid_rst_opcode", 32'(alu_opcode), 32'd25);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("post_rst_quiet", 32'(rsp_valid), 32'd0);

    send(5'd18, 16'd0, 16'd7, 32'd7, 1'b0, 16'd7, 1'b1);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
